// File: rtl/text_banner_scheduler.sv
// Frame-synchronous banner sequencer: holds, scrolls out, blanks, then scrolls in the next
// text banner, and registers the selected banner's overlay pixel for the colour mux.
module text_banner_scheduler #(
  parameter int NUM_BANNERS = 4,
  parameter int HOLD_FRAMES = 120,
  parameter int SCROLL_DIV  = 2,
  parameter int SCROLL_SPAN = 80,
  parameter int GAP_FRAMES  = 30
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           frame_start,
  input  logic                           skip_req,
  input  logic [NUM_BANNERS-1:0]         overlay_in,
  output logic                           skip_ack,
  output logic [$clog2(NUM_BANNERS)-1:0] banner_sel,
  output logic [6:0]                     scroll_cells,
  output logic                           overlay_active,
  output logic                           busy
);

  localparam int SEL_W   = $clog2(NUM_BANNERS);
  localparam int CNT_MAX = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIV_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCROLL_DIV - 1);
  localparam logic [6:0]       SPAN      = 7'(SCROLL_SPAN);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_BANNERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_SCROLL_OUT,
    S_GAP,
    S_SCROLL_IN
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [SEL_W-1:0] sel_reg, sel_next, sel_inc;
  logic [6:0]       scroll_reg, scroll_next;
  logic             overlay_reg, overlay_next;
  logic             skip_ack_reg, skip_ack_next;
  logic             busy_reg, busy_next;
  logic             skip_accept;
  logic             div_step;

  assign cnt_inc  = cnt_reg + CNT_W'(1);
  assign sel_inc  = (sel_reg == SEL_LAST) ? '0 : sel_reg + SEL_W'(1);
  assign div_step = (div_reg == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      div_reg      <= '0;
      sel_reg      <= '0;
      scroll_reg   <= '0;
      overlay_reg  <= 1'b0;
      skip_ack_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      div_reg      <= div_next;
      sel_reg      <= sel_next;
      scroll_reg   <= scroll_next;
      overlay_reg  <= overlay_next;
      skip_ack_reg <= skip_ack_next;
      busy_reg     <= busy_next;
    end
  end

  // Dropping enable aborts immediately; everything else advances only on frame_start.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    div_next    = div_reg;
    sel_next    = sel_reg;
    scroll_next = scroll_reg;
    skip_accept = 1'b0;
    if (!enable) begin
      state_next  = S_IDLE;
      cnt_next    = '0;
      div_next    = '0;
      sel_next    = '0;
      scroll_next = '0;
    end else if (frame_start) begin
      case (state_reg)
        S_IDLE: begin
          state_next  = S_HOLD;
          cnt_next    = '0;
          div_next    = '0;
          sel_next    = '0;
          scroll_next = '0;
        end
        S_HOLD: begin
          // The incremented count reaching HOLD_FRAMES-1 ends the hold.
          if (skip_req || (cnt_inc >= HOLD_LAST)) begin
            state_next  = S_SCROLL_OUT;
            cnt_next    = '0;
            div_next    = '0;
            skip_accept = skip_req;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        S_SCROLL_OUT: begin
          if (div_step) begin
            div_next    = '0;
            scroll_next = scroll_reg + 7'd1;
            if (scroll_reg + 7'd1 == SPAN) begin
              cnt_next = '0;
              if (GAP_FRAMES == 0) begin
                state_next = S_SCROLL_IN;
                sel_next   = sel_inc;
              end else begin
                state_next = S_GAP;
              end
            end
          end else begin
            div_next = div_reg + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            state_next = S_SCROLL_IN;
            sel_next   = sel_inc;
            cnt_next   = '0;
            div_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        S_SCROLL_IN: begin
          if (div_step) begin
            div_next    = '0;
            scroll_next = scroll_reg - 7'd1;
            if (scroll_reg == 7'd1) begin
              state_next = S_HOLD;
              cnt_next   = '0;
            end
          end else begin
            div_next = div_reg + DIV_W'(1);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_next     = (state_next != S_IDLE);
    skip_ack_next = skip_accept;
    overlay_next  = overlay_in[sel_reg] & enable &
                    ((state_reg == S_HOLD) || (state_reg == S_SCROLL_OUT) ||
                     (state_reg == S_SCROLL_IN));
  end

  assign skip_ack       = skip_ack_reg;
  assign banner_sel     = sel_reg;
  assign scroll_cells   = scroll_reg;
  assign overlay_active = overlay_reg;
  assign busy           = busy_reg;

endmodule

// File: tb/tb_text_banner_scheduler.sv
// Directed bench for text_banner_scheduler: two instances (gap of 2 frames and no gap)
// share stimulus; expected values are hand-derived from the frame schedule.
module tb_text_banner_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       frame_start;
  logic       skip_req;
  logic [3:0] overlay_in;

  logic       skip_ack, overlay_active, busy;
  logic [1:0] banner_sel;
  logic [6:0] scroll_cells;

  logic       g0_skip_ack, g0_overlay_active, g0_busy;
  logic [1:0] g0_banner_sel;
  logic [6:0] g0_scroll_cells;

  int n_tests = 0;
  int n_fail  = 0;

  text_banner_scheduler #(
    .NUM_BANNERS(4), .HOLD_FRAMES(3), .SCROLL_DIV(1), .SCROLL_SPAN(4), .GAP_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .skip_req(skip_req), .overlay_in(overlay_in), .skip_ack(skip_ack),
    .banner_sel(banner_sel), .scroll_cells(scroll_cells),
    .overlay_active(overlay_active), .busy(busy)
  );

  text_banner_scheduler #(
    .NUM_BANNERS(4), .HOLD_FRAMES(3), .SCROLL_DIV(1), .SCROLL_SPAN(4), .GAP_FRAMES(0)
  ) dut_g0 (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .skip_req(skip_req), .overlay_in(overlay_in), .skip_ack(g0_skip_ack),
    .banner_sel(g0_banner_sel), .scroll_cells(g0_scroll_cells),
    .overlay_active(g0_overlay_active), .busy(g0_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One frame_start pulse followed by a quiet cycle; called and returns on a negedge.
  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_start = 1'b0; skip_req = 1'b0; overlay_in = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sel", banner_sel, 0);
    check("rst_scroll", scroll_cells, 0);
    check("rst_overlay", overlay_active, 0);
    check("rst_skip_ack", skip_ack, 0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);

    // Enter HOLD, then reset asynchronously between clock edges.
    frame();
    check("hold_busy", busy, 1);
    check("hold_overlay", overlay_active, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_overlay", overlay_active, 0);
    check("async_rst_scroll", scroll_cells, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Three frame_starts: IDLE->HOLD, hold, ->SCROLL_OUT.
    frame(); frame(); frame();
    check("t1_scroll_home", scroll_cells, 0);
    check("t1_busy", busy, 1);

    for (int i = 1; i <= 4; i++) begin
      frame();
      check($sformatf("t2_out_scroll%0d", i), scroll_cells, i);
    end
    check("t2_gap_overlay0", overlay_active, 0);
    check("t2_gap_sel", banner_sel, 0);
    frame();
    check("t2_gap2_overlay", overlay_active, 0);
    check("t2_gap2_scroll", scroll_cells, 4);
    frame();
    check("t2_in_sel", banner_sel, 1);
    check("t2_in_scroll", scroll_cells, 4);
    check("t2_in_overlay", overlay_active, 1);
    for (int v = 3; v >= 0; v--) begin
      frame();
      check($sformatf("t2_in_scroll%0d", v), scroll_cells, v);
    end
    check("t2_back_hold_sel", banner_sel, 1);

    // One full banner cycle is 12 frame_starts with these parameters.
    repeat (12) frame();
    check("t3_sel2", banner_sel, 2);
    check("t3_scroll_home", scroll_cells, 0);

    // Overlay selection in HOLD with banner 2 shown.
    overlay_in = 4'b0000;
    @(negedge clk); @(negedge clk);
    check("t4_ovl_off", overlay_active, 0);
    overlay_in = 4'b0100;
    #1;
    check("t4_ovl_not_yet", overlay_active, 0);
    @(negedge clk);
    check("t4_ovl_1clk", overlay_active, 1);
    overlay_in = 4'b0101;
    @(negedge clk);
    check("t4_ovl_bit0_set", overlay_active, 1);
    overlay_in = 4'b0001;
    @(negedge clk);
    check("t4_ovl_bit2_clr", overlay_active, 0);
    overlay_in = 4'b1111;
    @(negedge clk);

    repeat (12) frame();
    check("t3_sel3", banner_sel, 3);
    repeat (12) frame();
    check("t3_sel_wrap", banner_sel, 0);

    // Skip on the first HOLD frame_start.
    frame_start = 1'b1; skip_req = 1'b1;
    @(negedge clk);
    check("t5_skip_ack", skip_ack, 1);
    frame_start = 1'b0;
    @(negedge clk);
    check("t5_skip_ack_pulse", skip_ack, 0);
    check("t5_scroll_home", scroll_cells, 0);
    frame_start = 1'b1;
    @(negedge clk);
    check("t5_no_ack_out", skip_ack, 0);
    frame_start = 1'b0;
    @(negedge clk);
    check("t5_out_scroll1", scroll_cells, 1);
    skip_req = 1'b0;

    // Reach SCROLL_IN with scroll_cells=2, then abort.
    frame(); frame(); frame();
    frame(); frame();
    frame(); frame();
    check("t6_in_scroll2", scroll_cells, 2);
    check("t6_in_sel", banner_sel, 1);
    enable = 1'b0;
    @(negedge clk);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_scroll", scroll_cells, 0);
    check("t6_abort_sel", banner_sel, 0);
    check("t6_abort_overlay", overlay_active, 0);
    check("t6_g0_abort_busy", g0_busy, 0);

    // No-gap instance goes straight from SCROLL_OUT to SCROLL_IN.
    enable = 1'b1;
    @(negedge clk);
    frame(); frame(); frame();
    repeat (3) frame();
    check("t6_g0_scroll3", g0_scroll_cells, 3);
    frame();
    check("t6_g0_sel_adv", g0_banner_sel, 1);
    check("t6_g0_scroll4", g0_scroll_cells, 4);
    check("t6_gap_sel_hold", banner_sel, 0);
    frame();
    check("t6_g0_in_scroll3", g0_scroll_cells, 3);
    check("t6_g0_in_overlay", g0_overlay_active, 1);
    check("t6_gap_scroll_hold", scroll_cells, 4);
    check("t6_gap_overlay", overlay_active, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_banner_scheduler.md
Name: text_banner_scheduler

Overview:
- Frame-synchronous sequencer that time-shares the 64x16-cell (8-px cell) overlay area between NUM_BANNERS text-overlay ROM blocks.
- Each banner is held on screen, scrolled out left, followed by a blank gap; the next banner then scrolls in from the right.
- Drives the shared cell-offset used by all text blocks, and selects and registers the single overlay_active fed to the pixel colour mux.
- All state changes only on frame_start, so there is no tearing.

Parameters:
- NUM_BANNERS, 4, number of banner sources (2..8); selector width is clog2(NUM_BANNERS).
- HOLD_FRAMES, 120, frames a banner sits at home position (1..255).
- SCROLL_DIV, 2, frames per 1-cell scroll step (1..15).
- SCROLL_SPAN, 80, cells scrolled before banner is fully off-screen (1..127).
- GAP_FRAMES, 30, blank frames between banners (0..255; 0 = no GAP state).

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, scheduler run; low forces IDLE.
- frame_start, input, 1, one-cycle pulse at start of vertical blanking.
- skip_req, input, 1, level request to advance current banner early.
- overlay_in, input, NUM_BANNERS, per-banner overlay_active from text blocks, index = banner id.
- skip_ack, output, 1, one-cycle pulse when a skip is accepted.
- banner_sel, output, clog2(NUM_BANNERS), banner currently shown.
- scroll_cells, output, 7, cell offset added to every text block's x origin (0 = home).
- overlay_active, output, 1, registered selected overlay pixel.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, banner_sel=0, scroll_cells=0, frame counter=0, overlay_active=0, skip_ack=0, busy=0.
- States: IDLE, HOLD, SCROLL_OUT, GAP, SCROLL_IN. Transitions are evaluated only on cycles with frame_start=1, except the enable-low override.
- IDLE -> HOLD: on frame_start with enable=1; banner_sel=0, scroll_cells=0, counter=0.
- HOLD:
  - Counter increments per frame_start.
  - When counter reaches HOLD_FRAMES-1 -> SCROLL_OUT, counter=0.
  - skip_req=1 on a frame_start -> SCROLL_OUT immediately, counter=0, skip_ack=1 for that cycle only.
  - skip_req is ignored in all other states, and skip_ack stays 0.
- SCROLL_OUT:
  - Every SCROLL_DIV frame_starts, scroll_cells += 1.
  - On the step that makes scroll_cells == SCROLL_SPAN: -> GAP, counter=0. If GAP_FRAMES=0, go directly to SCROLL_IN on that step.
- GAP:
  - Overlay is blanked.
  - After GAP_FRAMES frame_starts -> SCROLL_IN; banner_sel advances (wraps NUM_BANNERS-1 -> 0); scroll_cells stays SCROLL_SPAN.
- SCROLL_IN:
  - Every SCROLL_DIV frame_starts, scroll_cells -= 1.
  - On reaching 0 -> HOLD, counter=0.
- The banner_sel advance on the last GAP frame_start and the scroll_cells update become visible together on the next cycle.
- overlay_active:
  - Next-cycle value is overlay_in[banner_sel] & (state in HOLD, SCROLL_OUT, SCROLL_IN) & enable.
  - Latency is exactly 1 clk from overlay_in.
  - Out-of-range banner_sel cannot occur.
- enable low in any state: next cycle goes to IDLE with the reset values (not frame-gated). This is also the mid-operation abort.
- frame_start and enable falling in the same cycle: IDLE wins.
- busy is registered alongside state.
- Counter and step-divider widths are sized to parameters; no wrap occurs before the terminal compare.

Test Plan:
1. Params HOLD=3, DIV=1, SPAN=4, GAP=2, N=4; rst pulse mid-frame -> all outputs 0 immediately. Then enable=1 plus 3 frame_starts -> state is SCROLL_OUT after the 3rd.
2. Same params, run one full cycle -> scroll_cells goes 1,2,3,4 over 4 frames, then 2 GAP frames with overlay_active=0 despite overlay_in=4'b1111. Then banner_sel=1, scroll_cells goes 3,2,1,0, then HOLD.
3. Run 4 full banner cycles -> banner_sel sequence 0,1,2,3,0 (wrap).
4. overlay_in=4'b0100, force banner_sel=2 in HOLD, toggle overlay_in[2] -> overlay_active follows exactly 1 clk later. Toggle overlay_in[0] -> no effect.
5. skip_req=1 at the 1st HOLD frame_start -> skip_ack one-cycle pulse and state SCROLL_OUT. skip_req held during SCROLL_OUT -> no further skip_ack.
6. enable dropped during SCROLL_IN with scroll_cells=2 -> next cycle: IDLE, scroll_cells=0, banner_sel=0, busy=0. GAP=0 variant -> SCROLL_OUT goes straight to SCROLL_IN.
